// File: rtl/long_mul_unit_pkg.sv
// Shared encodings for the iterative long multiplier: operation codes and FSM states.
package long_mul_unit_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL   = 2'b00,
    MUL_OP_UMULL = 2'b01,
    MUL_OP_RSVD  = 2'b10,
    MUL_OP_SMULL = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/long_mul_unit.sv
// Iterative shift-add multiplier (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), one multiplier
// bit per cycle, feeding the register-file write port on the done pulse.
module long_mul_unit
  import long_mul_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mul_op,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [3:0]       wa_lo,
  input  logic [3:0]       wa_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             long_out,
  output logic [3:0]       wa3_out,
  output logic [3:0]       wa4_out
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  // Two's-complement magnitude; the most-negative value maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
    return neg ? (~p + PW'(1)) : p;
  endfunction

  mul_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             long_q, long_d;
  logic [3:0]       wa3_q, wa3_d;
  logic [3:0]       wa4_q, wa4_d;

  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [1:0]       op_q, op_d;
  logic             acc_q, acc_d;
  logic [PW-1:0]    accw_q, accw_d;
  logic [3:0]       wal_q, wal_d;
  logic [3:0]       wah_q, wah_d;

  logic             in_signed;
  logic [WIDTH-1:0] a_eff, b_eff;
  logic [PW-1:0]    step_sum;
  logic [PW-1:0]    prod_fin;
  logic             last_step;

  assign in_signed = (mul_op == MUL_OP_SMULL);
  assign a_eff     = in_signed ? magnitude($signed(a)) : a;
  assign b_eff     = in_signed ? magnitude($signed(b)) : b;

  // The final iteration's sum is folded straight into sign fix-up and accumulate,
  // so the results register on the last RUN edge and are valid throughout DONE.
  assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fin  = apply_sign(step_sum, neg_q) + (acc_q ? accw_q : '0);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    long_d   = long_q;
    wa3_d    = wa3_q;
    wa4_d    = wa4_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    op_d     = op_q;
    acc_d    = acc_q;
    accw_d   = accw_q;
    wal_d    = wal_q;
    wah_d    = wah_q;

    case (state_q)
      RUN: begin
        prod_d   = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = DONE;
          done_d   = 1'b1;
          res_lo_d = prod_fin[WIDTH-1:0];
          res_hi_d = (op_q == MUL_OP_MUL) ? '0 : prod_fin[PW-1:WIDTH];
          long_d   = (op_q != MUL_OP_MUL);
          wa3_d    = wal_q;
          wa4_d    = wah_q;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          prod_d   = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_eff};
          mplier_d = b_eff;
          neg_d    = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          op_d     = mul_op;
          acc_d    = acc;
          accw_d   = (mul_op == MUL_OP_MUL) ? {{WIDTH{1'b0}}, acc_lo} : {acc_hi, acc_lo};
          wal_d    = wa_lo;
          wah_d    = wa_hi;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      long_q   <= 1'b0;
      wa3_q    <= '0;
      wa4_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      long_q   <= long_d;
      wa3_q    <= wa3_d;
      wa4_q    <= wa4_d;
    end
  end

  // Operand/product datapath is always reloaded on accept, so it carries no reset.
  always_ff @(posedge clk) begin
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    neg_q    <= neg_d;
    op_q     <= op_d;
    acc_q    <= acc_d;
    accw_q   <= accw_d;
    wal_q    <= wal_d;
    wah_q    <= wah_d;
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign res_lo   = res_lo_q;
  assign res_hi   = res_hi_q;
  assign long_out = long_q;
  assign wa3_out  = wa3_q;
  assign wa4_out  = wa4_q;

endmodule
